// File: rtl/axi_mig_bridge.sv
// AXI4 slave to MIG app_* bridge: one 16-byte MIG command per AXI beat, with a single command in flight.
// Reads and writes are serialized through one FSM; AW/AR arbitration alternates on contention.
module axi_mig_bridge #(
  parameter int IDW = 4,
  parameter int AW  = 28
) (
  input  logic             mclk,
  input  logic             mrst_n,
  input  logic [IDW-1:0]   awid,
  input  logic [AW-1:0]    awaddr,
  input  logic [7:0]       awlen,
  input  logic             awvalid,
  output logic             awready,
  input  logic [127:0]     wdata,
  input  logic [15:0]      wstrb,
  input  logic             wlast,
  input  logic             wvalid,
  output logic             wready,
  output logic [IDW-1:0]   bid,
  output logic [1:0]       bresp,
  output logic             bvalid,
  input  logic             bready,
  input  logic [IDW-1:0]   arid,
  input  logic [AW-1:0]    araddr,
  input  logic [7:0]       arlen,
  input  logic             arvalid,
  output logic             arready,
  output logic [IDW-1:0]   rid,
  output logic [127:0]     rdata,
  output logic [1:0]       rresp,
  output logic             rlast,
  output logic             rvalid,
  input  logic             rready,
  output logic [AW-1:0]    app_addr,
  output logic [2:0]       app_cmd,
  output logic             app_en,
  input  logic             app_rdy,
  output logic [127:0]     app_wdf_data,
  output logic [15:0]      app_wdf_mask,
  output logic             app_wdf_wren,
  output logic             app_wdf_end,
  input  logic             app_wdf_rdy,
  input  logic [127:0]     app_rd_data,
  input  logic             app_rd_data_end,
  input  logic             app_rd_data_valid
);

  typedef enum logic [2:0] {IDLE, WCMD, WDAT, WRSP, RCMD, RWAIT, RDAT} state_t;

  state_t         state;
  logic [IDW-1:0] id_q;
  logic [AW-1:0]  addr_q;
  logic [7:0]     len_q;
  logic [7:0]     beat_cnt;
  logic           err;
  logic           last_grant_w;
  logic           last_beat;
  logic           grant_w;
  logic           grant_r;
  logic           unused_ok;

  assign unused_ok = ^{app_rd_data_end, awaddr[3:0], araddr[3:0]};

  assign last_beat = (beat_cnt == len_q);

  // Arbitration only matters when both address channels are valid together.
  assign grant_w = (state == IDLE) && awvalid && (!arvalid || !last_grant_w);
  assign grant_r = (state == IDLE) && arvalid && (!awvalid || last_grant_w);

  assign awready      = grant_w;
  assign arready      = grant_r;
  assign wready       = (state == WDAT) && app_wdf_rdy;
  assign app_wdf_wren = wready && wvalid;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = wdata;
  assign app_wdf_mask = ~wstrb;
  assign app_en       = (state == WCMD) || (state == RCMD);
  assign app_cmd      = (state == RCMD) ? 3'b001 : 3'b000;
  assign app_addr     = addr_q;
  assign bvalid       = (state == WRSP);
  assign bresp        = (bvalid && err) ? 2'b10 : 2'b00;
  assign bid          = id_q;
  assign rid          = id_q;
  assign rvalid       = (state == RDAT);
  assign rlast        = rvalid && last_beat;
  assign rresp        = 2'b00;

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state        <= IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
      err          <= 1'b0;
      last_grant_w <= 1'b0;
      rdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_w) begin
            id_q     <= awid;
            addr_q   <= {awaddr[AW-1:4], 4'b0000};
            len_q    <= awlen;
            beat_cnt <= '0;
            err      <= 1'b0;
            if (arvalid) last_grant_w <= 1'b1;
            state    <= WCMD;
          end else if (grant_r) begin
            id_q     <= arid;
            addr_q   <= {araddr[AW-1:4], 4'b0000};
            len_q    <= arlen;
            beat_cnt <= '0;
            err      <= 1'b0;
            if (awvalid) last_grant_w <= 1'b0;
            state    <= RCMD;
          end
        end
        WCMD: if (app_rdy) state <= WDAT;
        WDAT: begin
          if (wvalid && app_wdf_rdy) begin
            if (wlast != last_beat) err <= 1'b1;
            if (last_beat) begin
              state <= WRSP;
            end else begin
              addr_q   <= addr_q + AW'(16);
              beat_cnt <= beat_cnt + 8'd1;
              state    <= WCMD;
            end
          end
        end
        WRSP: if (bready) state <= IDLE;
        RCMD: if (app_rdy) state <= RWAIT;
        RWAIT: begin
          if (app_rd_data_valid) begin
            rdata <= app_rd_data;
            state <= RDAT;
          end
        end
        RDAT: begin
          if (rready) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              addr_q   <= addr_q + AW'(16);
              beat_cnt <= beat_cnt + 8'd1;
              state    <= RCMD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_mig_bridge.md
Name: axi_mig_bridge

Overview:
AXI4 slave that converts 128-bit AXI write and read bursts into MIG user-interface (app_*) commands, one 16-byte MIG command per AXI beat. It sits directly upstream of the MIG (real or the sim memory model) and is the memory target on the system AXI interconnect. Only one MIG command is outstanding at a time; reads and writes are serialized.

Parameters:
IDW, 4, AXI ID width (awid/arid echoed on bid/rid)
AW, 28, address width, matching app_addr

Ports:
mclk  in  1  clock; AXI and MIG share this domain
mrst_n  in  1  asynchronous active-low reset
awid  in  IDW  write ID
awaddr  in  AW  write byte address; bits [3:0] ignored
awlen  in  8  beats-1
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  128  write data
wstrb  in  16  byte enables
wlast  in  1  last write beat
wvalid  in  1  write data valid
wready  out  1  write data ready
bid  out  IDW  response ID
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
arid  in  IDW  read ID
araddr  in  AW  read byte address; bits [3:0] ignored
arlen  in  8  beats-1
arvalid  in  1  read address valid
arready  out  1  read address ready
rid  out  IDW  read ID
rdata  out  128  read data
rresp  out  2  read response, always 2'b00
rlast  out  1  last read beat
rvalid  out  1  read data valid
rready  in  1  read data ready
app_addr  out  AW  MIG address
app_cmd  out  3  3'b000 write, 3'b001 read
app_en  out  1  command valid
app_rdy  in  1  command accepted when app_en&app_rdy
app_wdf_data  out  128  = wdata
app_wdf_mask  out  16  = ~wstrb (1 = byte masked)
app_wdf_wren  out  1  write data strobe
app_wdf_end  out  1  = app_wdf_wren (one beat per command)
app_wdf_rdy  in  1  MIG ready for write data
app_rd_data  in  128  MIG read data
app_rd_data_end  in  1  unused
app_rd_data_valid  in  1  read data valid

Behaviour:
- FSM states: IDLE, WCMD, WDAT, WRSP, RCMD, RWAIT, RDAT. Reset -> IDLE. Every valid/ready/app_en/wren output is 0 in reset. app_addr, rdata, bresp, rid and bid reset to 0.
- IDLE: awready and arready are combinational and high only for the granted channel. If only one channel is valid, it is granted. If both are valid, grant alternates using a last_grant flag (reset = read, so the first contest goes to write). On the AW handshake: latch id, addr[AW-1:4]<<4 and len; clear beat_cnt; clear err; go to WCMD. On the AR handshake: same latching; go to RCMD.
- WCMD: app_en=1, app_cmd=000. On app_rdy go to WDAT.
- WDAT: wready=app_wdf_rdy; app_wdf_wren=wvalid&app_wdf_rdy. The data beat is consumed on wvalid&wready.
  - If wlast != (beat_cnt==len), set err.
  - If beat_cnt==len, go to WRSP. Otherwise addr+=16 (wraps modulo 2^AW), beat_cnt++, go to WCMD.
- WRSP: bvalid=1, bresp = err ? 2'b10 : 2'b00. On bready go to IDLE.
- RCMD: app_en=1, app_cmd=001. On app_rdy go to RWAIT.
- RWAIT: on app_rd_data_valid, capture app_rd_data into the rdata register and go to RDAT. Latency is unbounded.
- RDAT: rvalid=1, rlast=(beat_cnt==len). rdata is held stable until the handshake. On rready: if last, go to IDLE; otherwise addr+=16, beat_cnt++, go to RCMD.
- app_en is held high until app_rdy, with app_addr and app_cmd stable. Write data is never driven before its command is accepted.
- Read data arriving outside RWAIT is ignored.
- awlen=255 produces 256 commands; beat_cnt is 8 bits.
- Asserting mrst_n mid-burst returns the FSM to IDLE and drops the partial transaction with no response.

Test Plan:
- Single write: awaddr=0x40, awlen=0, wdata=0x1122..FF, wstrb=0xFFFF -> one command with app_cmd=000, app_addr=0x40, app_wdf_mask=0x0000, one wren; bvalid with bresp=00 and bid=awid.
- Read-back: araddr=0x40, arlen=0 against the 15-cycle-latency sim MIG -> rvalid exactly 1 cycle after app_rd_data_valid, rdata=the written value, rlast=1, rid=arid.
- 4-beat write then 4-beat read at 0x100 -> MIG addresses 0x100, 0x110, 0x120, 0x130 in order; read data matches per beat; rlast only on beat 3.
- Simultaneous awvalid and arvalid after reset -> write granted first, then read; next contest grants read.
- Backpressure: hold rready=0 for 20 cycles on beat 1 -> rdata stable, no new app_en; wvalid low 5 cycles in WDAT -> wren stays 0.
- awlen=1 with wlast on beat 0 -> bresp=2'b10. Reset asserted in RWAIT -> all outputs 0 and FSM in IDLE next cycle.
